// File: rtl/bypass_buffer_ctrl_pkg.sv
// bypass_buffer_ctrl_pkg: shared channel geometry and controller state encodings
package bypass_buffer_ctrl_pkg;
  localparam int NUM_CHANNEL = 5;
  localparam int NUM_PORT = 6;
  localparam int BYPASS_BIT = NUM_PORT - 1;
  localparam int FLIT_WIDTH = 64;
  typedef enum logic [1:0] {EMPTY = 2'd0, ACTIVE = 2'd1, STARVED = 2'd2} state_t;
endpackage

// File: rtl/bypass_buffer_ctrl_fifo.sv
// multi_enq_fifo: circular buffer taking up to NCH in-order writes and one read per cycle
module multi_enq_fifo import bypass_buffer_ctrl_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int NCH = NUM_CHANNEL,
  parameter int W = FLIT_WIDTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] wr_mask,
  input  logic [NCH*W-1:0] wr_data,
  input  logic           rd,
  output logic [W-1:0]   rd_data,
  output logic [AW:0]    count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW-1:0] ofs [NCH];
  logic [AW:0] n_wr;
  // Masked channels pack into consecutive slots; the caller never writes past free space.
  always_comb begin
    n_wr = '0;
    for (int i = 0; i < NCH; i++) begin
      ofs[i] = n_wr[AW-1:0];
      n_wr = n_wr + (AW+1)'(wr_mask[i]);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + n_wr[AW-1:0];
      rp <= rp + AW'(rd);
      count <= count + n_wr - (AW+1)'(rd);
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++)
      if (!reset && wr_mask[i]) mem[wp + ofs[i]] <= wr_data[i*W +: W];
  end
  assign rd_data = (count != '0) ? mem[rp] : '0;
endmodule

// File: rtl/bypass_buffer_ctrl.sv
// bypass_buffer_ctrl: buffers BYPASS-allocated flits, re-injects them, and flags starvation
module bypass_buffer_ctrl import bypass_buffer_ctrl_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int STARVE_LIMIT = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int SW = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CHANNEL*NUM_PORT-1:0]   PVIn,
  input  logic [NUM_CHANNEL*FLIT_WIDTH-1:0] flitIn,
  output logic [NUM_CHANNEL-1:0]            rejectVec,
  output logic [FLIT_WIDTH-1:0]             reinjFlit,
  output logic                              reinjValid,
  input  logic                              reinjReady,
  output logic                              starved,
  output logic [AW:0]                       occupancy
);
  logic [NUM_CHANNEL-1:0] acc;
  logic [AW:0] free, taken, cnt_next;
  logic xfer, unused_pv;
  state_t state, state_n;
  logic [SW-1:0] sc, sc_n;
  assign unused_pv = ^PVIn;
  assign reinjValid = occupancy != '0;
  assign xfer = reinjValid && reinjReady;
  assign starved = state == STARVED;
  // Free space is taken from the start-of-cycle count, so a same-cycle read frees nothing.
  always_comb begin
    free = (AW+1)'(DEPTH) - occupancy;
    taken = '0;
    acc = '0;
    rejectVec = '0;
    for (int i = 0; i < NUM_CHANNEL; i++) begin
      if (PVIn[i*NUM_PORT + BYPASS_BIT]) begin
        acc[i] = taken < free;
        rejectVec[i] = !(taken < free);
        taken = taken + (AW+1)'(acc[i]);
      end
    end
    cnt_next = occupancy + taken - (AW+1)'(xfer);
  end
  always_comb begin
    state_n = state;
    sc_n = sc;
    if (cnt_next == '0) begin
      state_n = EMPTY;
      sc_n = '0;
    end else if (state == EMPTY) begin
      state_n = ACTIVE;
    end else if (xfer) begin
      state_n = ACTIVE;
      sc_n = '0;
    end else begin
      sc_n = (sc == SW'(STARVE_LIMIT)) ? sc : sc + SW'(1);
      state_n = (sc_n == SW'(STARVE_LIMIT)) ? STARVED : state;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      sc <= '0;
    end else begin
      state <= state_n;
      sc <= sc_n;
    end
  end
  multi_enq_fifo #(.DEPTH(DEPTH), .NCH(NUM_CHANNEL), .W(FLIT_WIDTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .wr_mask(acc),
    .wr_data(flitIn),
    .rd(xfer),
    .rd_data(reinjFlit),
    .count(occupancy)
  );
endmodule
